xor_accumulator: RTL and testbench

XOR_ACCUMULATOR -- requirements
Module: xor_accumulator

---
 rtl/xor_accumulator.sv | 146 ++++++++++++++
 tb/tb_xor_accumulator.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_accumulator.sv
// -----------------------------------------------------------------------------
// xor_accumulator
//
// Folds a frame of input words into a single XOR result. A frame ends when
// FRAME_LEN words have been accepted, or earlier on a word flagged in_last.
// The result (XOR, its parity and the word count) is held in registers until
// the consumer takes it with out_ready. While a result is pending, no input
// is accepted.
//
// Parameters
//   WIDTH      data word width in bits (>= 1)
//   FRAME_LEN  maximum words per frame (>= 1)
//   CW         derived count width, $clog2(FRAME_LEN + 1)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   clr         synchronous abort of the current frame and any pending result
//   in_data     input word
//   in_valid    in_data is valid
//   in_last     accepted word ends the frame early
//   in_ready    block accepts a word this cycle (high exactly in ACCUM)
//   out_data    XOR of all words in the frame
//   out_parity  reduction XOR of out_data
//   out_count   number of words in the frame
//   out_valid   result is valid
//   out_ready   consumer takes the result
// -----------------------------------------------------------------------------
module xor_accumulator #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FRAME_LEN = 4,
    localparam int unsigned CW       = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [0:0] {
        StAccum,
        StDone
    } state_e;

    // Count value held before the word that completes a full-length frame.
    localparam logic [CW-1:0] LastCnt = CW'(FRAME_LEN - 1);

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_parity_q;
    logic [CW-1:0]    out_count_q;
    logic             out_valid_q;

    logic             accept;
    logic             frame_end;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt_next;

    // in_ready depends on state only so upstream never sees a combinational
    // path from its own valid or from the downstream ready.
    assign in_ready = (state_q == StAccum);

    always_comb begin
        accept    = in_ready && in_valid && !clr;
        acc_next  = acc_q ^ in_data;
        cnt_next  = cnt_q + CW'(1);
        // in_last on the FRAME_LEN-th word is the same single frame end.
        frame_end = accept && (in_last || (cnt_q == LastCnt));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StAccum;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_parity_q <= 1'b0;
            out_count_q  <= '0;
            out_valid_q  <= 1'b0;
        end else if (clr) begin
            // Abort wins over everything, including a word on in_data.
            state_q      <= StAccum;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_parity_q <= 1'b0;
            out_count_q  <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                StAccum: begin
                    if (frame_end) begin
                        out_data_q   <= acc_next;
                        out_parity_q <= ^acc_next;
                        out_count_q  <= cnt_next;
                        out_valid_q  <= 1'b1;
                        // Partial state is dead once the result is latched;
                        // clearing here keeps cnt_q bounded below FRAME_LEN.
                        acc_q        <= '0;
                        cnt_q        <= '0;
                        state_q      <= StDone;
                    end else if (accept) begin
                        acc_q <= acc_next;
                        cnt_q <= cnt_next;
                    end
                end
                StDone: begin
                    // Result registers hold until the consumer takes them.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        state_q     <= StAccum;
                    end
                end
                default: begin
                    state_q <= StAccum;
                end
            endcase
        end
    end

    assign out_data   = out_data_q;
    assign out_parity = out_parity_q;
    assign out_count  = out_count_q;
    assign out_valid  = out_valid_q;

`ifndef SYNTHESIS
    cnt_bounded_a : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StAccum) |-> (cnt_q <= LastCnt));

    valid_matches_state_a : assert property (@(posedge clk) disable iff (!rst_n)
        out_valid_q == (state_q == StDone));
`endif

endmodule

// File: tb/tb_xor_accumulator.sv
module tb_xor_accumulator;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned FRAME_LEN = 4;
    localparam int unsigned CW        = $clog2(FRAME_LEN + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_parity;
    logic [CW-1:0]    out_count;
    logic             out_valid;
    logic             out_ready = 1'b1;

    int tests = 0;
    int fails = 0;

    xor_accumulator #(
        .WIDTH     (WIDTH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_parity (out_parity),
        .out_count  (out_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a frame is a list of words; a result is either
    // pending or not. Output fields are only pinned once defined (after
    // reset, clr or a completed frame).
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] m_words[$];
    bit               m_pending = 1'b0;
    bit               m_defined = 1'b1;
    int unsigned      m_data    = 0;
    int unsigned      m_parity  = 0;
    int unsigned      m_count   = 0;

    task automatic model_clear_all();
        m_words.delete();
        m_pending = 1'b0;
        m_defined = 1'b1;
        m_data    = 0;
        m_parity  = 0;
        m_count   = 0;
    endtask

    task automatic model_step();
        logic [WIDTH-1:0] x;
        if (!rst_n || clr) begin
            model_clear_all();
        end else if (m_pending) begin
            if (out_ready) m_pending = 1'b0;
        end else if (in_valid) begin
            m_words.push_back(in_data);
            if (m_words.size() == FRAME_LEN || in_last) begin
                x = '0;
                foreach (m_words[i]) x = x ^ m_words[i];
                m_data    = 32'(x);
                m_parity  = 32'(^x);
                m_count   = m_words.size();
                m_pending = 1'b1;
                m_defined = 1'b1;
                m_words.delete();
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Compare DUT against the model every cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(!m_pending));
        check("out_valid", 32'(out_valid), 32'(m_pending));
        if (m_defined) begin
            check("out_data", 32'(out_data), m_data);
            check("out_parity", 32'(out_parity), m_parity);
            check("out_count", 32'(out_count), m_count);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus. Inputs change 1 time unit after each rising edge.
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic expect_result(input string tag, input logic [WIDTH-1:0] d, input logic p,
                                 input logic [CW-1:0] c);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(d));
        check({tag, "_parity"}, 32'(out_parity), 32'(p));
        check({tag, "_count"}, 32'(out_count), 32'(c));
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        // Reset state while rst_n is held low.
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        #20;
        rst_n = 1'b1;
        cyc();

        // Full frame back-to-back.
        send(8'hA5, 1'b0);
        send(8'h0F, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h3C, 1'b0);
        expect_result("full", 8'h69, 1'b0, 3'd4);
        cyc();
        check("full_ready_back", 32'(in_ready), 32'd1);
        check("full_valid_drop", 32'(out_valid), 32'd0);

        // Early last.
        send(8'h80, 1'b1);
        expect_result("early", 8'h80, 1'b1, 3'd1);
        idle(1);

        // in_last without in_valid is ignored; in_last on the 4th word is one frame.
        in_last = 1'b1;
        idle(2);
        in_last = 1'b0;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h04, 1'b0);
        send(8'h08, 1'b1);
        expect_result("last4", 8'h0F, 1'b0, 3'd4);
        idle(1);

        // Backpressure with bubbles; 0xEE held during DONE.
        out_ready = 1'b0;
        send(8'h01, 1'b0);
        idle(1);
        send(8'h02, 1'b0);
        idle(2);
        send(8'h04, 1'b0);
        send(8'h08, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            expect_result("bp_hold", 8'h0F, 1'b0, 3'd4);
            if (i < 4) cyc();
        end
        out_ready = 1'b1;
        cyc();
        check("bp_released", 32'(out_valid), 32'd0);
        cyc();
        in_valid = 1'b0;
        send(8'h11, 1'b1);
        expect_result("bp_next", 8'hFF, 1'b0, 3'd2);
        idle(1);

        // clr mid-frame with a word present.
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h33;
        cyc();
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clr_out_data", 32'(out_data), 32'd0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h04, 1'b0);
        send(8'h08, 1'b0);
        expect_result("clr_mid", 8'h0F, 1'b0, 3'd4);
        idle(1);

        // clr while a result is pending.
        out_ready = 1'b0;
        send(8'h07, 1'b1);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check("clr_done_valid", 32'(out_valid), 32'd0);
        check("clr_done_count", 32'(out_count), 32'd0);

        // Async reset while in DONE.
        send(8'h12, 1'b1);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_count", 32'(out_count), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        in_last   = 1'b1;
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_result("post_rst", 8'h55, 1'b0, 3'd1);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
